axi_to_ahb_master: RTL

- Bridge in the reverse direction of the DDR AHB path. It is an AXI4 slave that accepts bursts from AXI initiators (camera DMA, test masters) and replays each beat as an AHB-Lite master transfer onto the system bus matrix.
- One transaction is in flight at a time.
- Data width is 32 bits. Single clock domain on HCLK.

---
 rtl/axi_to_ahb_master.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_to_ahb_master.sv
// AXI4 slave that replays each burst beat as a single AHB-Lite master transfer, one burst at a time.
// Optional feature macro: AXI2AHB_WRAP_EN (true WRAP address sequencing; otherwise WRAP acts as INCR).
module axi_to_ahb_master #(
    parameter int unsigned ID_W      = 4,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic [ID_W-1:0] s_axi_awid,
    input  logic [31:0]     s_axi_awaddr,
    input  logic [7:0]      s_axi_awlen,
    input  logic [2:0]      s_axi_awsize,
    input  logic [1:0]      s_axi_awburst,
    input  logic            s_axi_awvalid,
    output logic            s_axi_awready,
    input  logic [31:0]     s_axi_wdata,
    input  logic [3:0]      s_axi_wstrb,
    input  logic            s_axi_wlast,
    input  logic            s_axi_wvalid,
    output logic            s_axi_wready,
    output logic [ID_W-1:0] s_axi_bid,
    output logic [1:0]      s_axi_bresp,
    output logic            s_axi_bvalid,
    input  logic            s_axi_bready,
    input  logic [ID_W-1:0] s_axi_arid,
    input  logic [31:0]     s_axi_araddr,
    input  logic [7:0]      s_axi_arlen,
    input  logic [2:0]      s_axi_arsize,
    input  logic [1:0]      s_axi_arburst,
    input  logic            s_axi_arvalid,
    output logic            s_axi_arready,
    output logic [ID_W-1:0] s_axi_rid,
    output logic [31:0]     s_axi_rdata,
    output logic [1:0]      s_axi_rresp,
    output logic            s_axi_rlast,
    output logic            s_axi_rvalid,
    input  logic            s_axi_rready,
    output logic [31:0]     HADDR,
    output logic [1:0]      HTRANS,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [31:0]     HWDATA,
    input  logic [31:0]     HRDATA,
    input  logic            HREADY,
    input  logic            HRESP
);

    typedef enum logic [2:0] {
        StIdle, StWDataWait, StWAph, StWDph, StBResp, StRAph, StRDph, StROut
    } state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [7:0]      len_q, len_d, beat_q, beat_d;
    logic [2:0]      size_q, size_d;
    logic [1:0]      burst_q, burst_d, rresp_q, rresp_d;
    logic            err_q, err_d, last_wr_q, last_wr_d;

    logic            grant_wr, grant_rd, both_req, last_beat, wrap_bad;
    logic [1:0]      size_eff;
    logic [31:0]     addr_inc, next_addr;
    logic            unused_inputs;

    assign unused_inputs = ^{s_axi_wstrb, s_axi_wlast};
    assign size_eff      = (size_q > 3'd2) ? 2'd2 : size_q[1:0];
    assign addr_inc      = addr_q + (32'd1 << size_eff);
    assign last_beat     = (beat_q == len_q);
    assign both_req      = s_axi_awvalid && s_axi_arvalid;

`ifdef AXI2AHB_WRAP_EN
    logic [31:0] wrap_mask;
    assign wrap_mask = ((32'(len_q) + 32'd1) << size_eff) - 32'd1;
    // Only 2/4/8/16-beat WRAP bursts are legal; others are answered with SLVERR and never hit AHB.
    assign wrap_bad  = (burst_q == 2'b10) && !(len_q inside {8'd1, 8'd3, 8'd7, 8'd15});
`else
    assign wrap_bad  = 1'b0;
`endif

    always_comb begin
        case (burst_q)
            2'b00:   next_addr = addr_q;
`ifdef AXI2AHB_WRAP_EN
            2'b10:   next_addr = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
`endif
            default: next_addr = addr_inc;
        endcase
    end

    // Simultaneous requests alternate; a lone request is granted without touching the history.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (HRESETn && state_q == StIdle) begin
            if (both_req) begin
                grant_wr = !last_wr_q;
                grant_rd = last_wr_q;
            end else begin
                grant_wr = s_axi_awvalid;
                grant_rd = s_axi_arvalid;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q   <= StIdle;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            last_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            last_wr_q <= last_wr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        err_d     = err_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        last_wr_d = last_wr_q;
        unique case (state_q)
            StIdle: begin
                if (grant_wr) begin
                    id_d    = s_axi_awid;
                    addr_d  = s_axi_awaddr;
                    len_d   = s_axi_awlen;
                    size_d  = s_axi_awsize;
                    burst_d = s_axi_awburst;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = StWDataWait;
                end else if (grant_rd) begin
                    id_d    = s_axi_arid;
                    addr_d  = s_axi_araddr;
                    len_d   = s_axi_arlen;
                    size_d  = s_axi_arsize;
                    burst_d = s_axi_arburst;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = StRAph;
                end
                if (both_req) last_wr_d = grant_wr;
            end
            StWDataWait: begin
                if (s_axi_wvalid) begin
                    wdata_d = s_axi_wdata;
                    state_d = StWAph;
                end
            end
            StWAph: begin
                if (wrap_bad) begin
                    if (last_beat) begin
                        state_d = StBResp;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        addr_d  = next_addr;
                        state_d = StWDataWait;
                    end
                end else if (HREADY) begin
                    state_d = StWDph;
                end
            end
            StWDph: begin
                if (HREADY) begin
                    err_d = err_q | HRESP;
                    if (last_beat) begin
                        state_d = StBResp;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        addr_d  = next_addr;
                        state_d = StWDataWait;
                    end
                end
            end
            StBResp: begin
                if (s_axi_bready) state_d = StIdle;
            end
            StRAph: begin
                if (wrap_bad)    state_d = StROut;
                else if (HREADY) state_d = StRDph;
            end
            StRDph: begin
                if (HREADY) begin
                    rdata_d = HRDATA;
                    rresp_d = HRESP ? 2'b10 : 2'b00;
                    state_d = StROut;
                end
            end
            StROut: begin
                if (s_axi_rready) begin
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        addr_d  = next_addr;
                        state_d = StRAph;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s_axi_awready = grant_wr;
        s_axi_arready = grant_rd;
        s_axi_wready  = (state_q == StWDataWait);
        s_axi_bvalid  = (state_q == StBResp);
        s_axi_bid     = id_q;
        s_axi_bresp   = ((state_q == StBResp) && (err_q || wrap_bad)) ? 2'b10 : 2'b00;
        s_axi_rvalid  = (state_q == StROut);
        s_axi_rid     = id_q;
        s_axi_rdata   = rdata_q;
        s_axi_rresp   = ((state_q == StROut) && wrap_bad) ? 2'b10 : rresp_q;
        s_axi_rlast   = (state_q == StROut) && last_beat;
        HTRANS        = (((state_q == StWAph) || (state_q == StRAph)) && !wrap_bad) ? 2'b10 : 2'b00;
        HWRITE        = (state_q == StWAph) || (state_q == StWDph);
        HADDR         = addr_q;
        HSIZE         = {1'b0, size_eff};
        HBURST        = 3'b000;
        HPROT         = HPROT_VAL;
        HWDATA        = wdata_q;
    end

endmodule
